uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised successor to the team's fixed 8N1 UART receiver, used for loading host data such as FIR coefficients.
- Configurable data width, parity mode and stop-bit count.
- Input synchroniser with 3-sample majority filtering and false-start rejection.
- Parity and framing error flags.
- Valid/ready output handshake with overrun detection.
- Sits between the board RX pin and the coefficient-loader/command FSM.

Parameters:
- CLK_FRE, 50000000, system clock frequency in Hz.
- UART_BPS, 9600, line bit rate; BPS_CNT = CLK_FRE/UART_BPS, HALF = BPS_CNT/2; BPS_CNT >= 8 required.
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst  input  1  reset, asynchronous, active-low.
- uart_r  input  1  asynchronous serial line, idle high.
- rx_ready  input  1  consumer can accept a word.
- rx_data  output  DATA_BITS  received word, LSB = first bit on the line.
- rx_valid  output  1  rx_data and the error flags are valid.
- rx_parity_err  output  1  parity mismatch for the held word; always 0 when PARITY = 0.
- rx_frame_err  output  1  a stop bit was sampled low for the held word.
- rx_overrun  output  1  at least one frame was dropped while rx_valid was pending.
- rx_busy  output  1  FSM not in IDLE.

Behaviour:

Reset:
- All outputs are 0; FSM is in IDLE.
- Synchroniser flops reset to 1 (line idle), so reset release never produces a false start.

Input path:
- 2-flop synchroniser, then a 3-deep shift register.
- Filtered bit rxf = majority of the 3 shift-register stages.
- Start detection: rxf falling edge (previous 1, current 0) while in IDLE.

Timing:
- Counter cnt has width sufficient for BPS_CNT.
- cnt is cleared on every state entry.

FSM states and transitions:
- IDLE: wait for start detection, then go to START.
- START: when cnt == HALF-1, sample rxf.
  - rxf = 1: false start, return to IDLE with no output.
  - rxf = 0: go to DATA, clear bit index.
- DATA: cnt counts 0..BPS_CNT-1; at BPS_CNT-1, shift rxf into the shift register LSB-first and increment the bit index.
  - After DATA_BITS samples, go to PARITY if PARITY != 0, else STOP.
- PARITY: sample at BPS_CNT-1.
  - perr = (XOR of data bits XOR sampled bit) != (PARITY == 1 ? 1 : 0).
  - Then go to STOP.
- STOP: sample at BPS_CNT-1, STOP_BITS times; any stop sample = 0 sets ferr.
  - After the last stop sample, go to IDLE in the same cycle, so a following start edge is accepted immediately (back-to-back frames).

Output update (complete = the cycle of the last stop sample):
- Latency: rx_valid, rx_data and the error flags update on the clock edge ending the last stop-sample cycle.
- That is mid-last-stop-bit plus 1 cycle, plus about 3 cycles of synchroniser/filter delay from the line.
- rx_valid = 0, or (rx_valid = 1 and rx_ready = 1) in the same cycle: load rx_data, rx_parity_err, rx_frame_err; rx_valid = 1; rx_overrun = 0.
- rx_valid = 1 and rx_ready = 0: new frame is discarded, held word is unchanged, rx_overrun set to 1.

Handshake:
- Transfer occurs when rx_valid & rx_ready.
- Without a simultaneous completion: rx_valid, error flags and rx_overrun clear next cycle; rx_data holds its last value.
- rx_valid never drops without a handshake.

Break / stuck-low line:
- Frame reports ferr = 1 and data = 0.
- No new start until rxf has returned high and then falls again.

Reset mid-frame:
- Immediately aborts the frame and clears all outputs.
- Next full frame after release is received correctly.

Test Plan:
Bench runs with CLK_FRE = 16 * UART_BPS (BPS_CNT = 16) plus one run at defaults.
1. Default parameters (8N1), send 0xA5 -> single rx_valid with rx_data = 0xA5, both error flags 0; rx_valid held until rx_ready pulse, then clears next cycle.
2. DATA_BITS = 7, PARITY = 2 (even), send 0x41 with correct parity 0, then with parity 1 -> first word 0x41 with perr = 0; second word 0x41 with rx_parity_err = 1.
3. STOP_BITS = 2, send 0x3C with the second stop bit driven low -> rx_data = 0x3C, rx_frame_err = 1.
4. 1-cycle low glitch, then a low pulse of HALF-2 cycles, on an idle line -> rx_valid stays 0, rx_busy returns to 0, no data output.
5. rx_ready = 0, send 0x11, 0x22 back-to-back -> rx_data = 0x11, rx_overrun = 1; after a handshake, rx_valid = 0 and rx_overrun = 0.
6. Assert sys_rst during data bit 3 of 0x5A, release, send 0xC3 -> outputs 0 during reset, no partial word, then rx_data = 0xC3 with no errors.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-filtered input, optional parity, 1 or 2 stop bits,
// valid/ready output with overrun tracking.
module uart_rx_param #(
  parameter int unsigned CLK_FRE   = 50000000,
  parameter int unsigned UART_BPS  = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_r,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int unsigned BpsCnt = CLK_FRE / UART_BPS;
  localparam int unsigned Half   = BpsCnt / 2;
  localparam int unsigned CntW   = $clog2(BpsCnt);
  localparam int unsigned IdxW   = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(BpsCnt - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Half - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);
  localparam bit HasParity = (PARITY != 0);
  localparam bit OddParity = (PARITY == 1);
  localparam bit TwoStop   = (STOP_BITS == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q;
  logic [1:0]           sync_q;
  logic [2:0]           filt_q;
  logic                 rxf_prev_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q;
  logic                 ferr_q;

  logic rxf;
  logic bit_tick;
  logic frame_done;

  assign rxf        = (filt_q[0] & filt_q[1]) | (filt_q[1] & filt_q[2]) | (filt_q[0] & filt_q[2]);
  assign bit_tick   = (cnt_q == CntLast);
  assign frame_done = (state_q == StStop) && bit_tick && (stop_idx_q || !TwoStop);
  assign rx_busy    = (state_q != StIdle);

  // Reset to idle-high so releasing reset never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync_q     <= 2'b11;
      filt_q     <= 3'b111;
      rxf_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], uart_r};
      filt_q     <= {filt_q[1:0], sync_q[1]};
      rxf_prev_q <= rxf;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      stop_idx_q    <= 1'b0;
      shift_q       <= '0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (rxf_prev_q && !rxf) state_q <= StStart;
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_q <= '0;
            if (rxf) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              bit_idx_q <= '0;
              perr_q    <= 1'b0;
              ferr_q    <= 1'b0;
            end
          end
        end
        StData: begin
          if (bit_tick) begin
            cnt_q     <= '0;
            shift_q   <= {rxf, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == IdxLast) begin
              state_q    <= HasParity ? StParity : StStop;
              stop_idx_q <= 1'b0;
            end
          end
        end
        StParity: begin
          if (bit_tick) begin
            cnt_q      <= '0;
            perr_q     <= ((^shift_q) ^ rxf) != OddParity;
            state_q    <= StStop;
            stop_idx_q <= 1'b0;
          end
        end
        StStop: begin
          if (bit_tick) begin
            cnt_q      <= '0;
            ferr_q     <= ferr_q | ~rxf;
            stop_idx_q <= 1'b1;
            // Straight back to idle mid-stop-bit so a back-to-back start edge is caught.
            if (stop_idx_q || !TwoStop) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= shift_q;
          rx_parity_err <= perr_q;
          rx_frame_err  <= ferr_q | ~rxf;
          rx_valid      <= 1'b1;
          rx_overrun    <= 1'b0;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid      <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_frame_err  <= 1'b0;
        rx_overrun    <= 1'b0;
      end
    end
  end

endmodule
